// File: rtl/insmem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package insmem_loader_pkg;

    localparam int unsigned PC_BITS_DEF = 6;
    localparam int unsigned WE_HOLD_DEF = 2;
    localparam int unsigned MAX_WORDS   = 1 << (PC_BITS_DEF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CHK  = 2'b10
    } load_err_t;

    // States in which the loader takes a byte from the host link.
    function automatic logic accepts_byte(input state_t s);
        return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/insmem_loader.sv
// Host byte stream -> instruction memory write port, with length/checksum validation.
module insmem_loader
    import insmem_loader_pkg::*;
#(
    parameter int unsigned PC_BITS = PC_BITS_DEF,
    parameter int unsigned WE_HOLD = WE_HOLD_DEF
) (
    input  logic               clka,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               we_insmem,
    output logic [PC_BITS-1:0] pc,
    output logic [15:0]        instruction_in,
    output logic               cpu_halt,
    output logic               load_done,
    output logic [1:0]         load_err
);

    localparam int unsigned IDX_W     = PC_BITS - 1;
    localparam int unsigned WORDS_CAP = 1 << IDX_W;
    localparam int unsigned HOLD_W    = (WE_HOLD < 2) ? 1 : $clog2(WE_HOLD + 1);

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [15:0]        instr_q, instr_d;
    logic               halt_q, halt_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [7:0]         csum_q, csum_d;
    logic               xfer;

    assign xfer = byte_valid & ready_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        pc_d       = pc_q;
        instr_d    = instr_q;
        halt_d     = halt_q;
        done_d     = done_q;
        err_d      = err_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        hold_d     = hold_q;
        csum_d     = csum_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN;
                    halt_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = ERR_NONE;
                    word_idx_d = '0;
                    csum_d     = '0;
                    hold_d     = '0;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if ((byte_in == 8'd0) || (32'(byte_in) > WORDS_CAP)) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                        halt_d  = 1'b0;
                    end else begin
                        last_idx_d = IDX_W'(32'(byte_in) - 32'd1);
                        state_d    = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (xfer) begin
                    instr_d[15:8] = byte_in;
                    csum_d        = csum_q ^ byte_in;
                    state_d       = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    instr_d[7:0] = byte_in;
                    csum_d       = csum_q ^ byte_in;
                    pc_d         = {word_idx_q, 1'b0};
                    we_d         = 1'b1;
                    hold_d       = '0;
                    state_d      = ST_WR;
                end
            end
            ST_WR: begin
                // WE_HOLD cycles with we high, then one settle cycle with pc/data held.
                if (hold_q < HOLD_W'(WE_HOLD - 1)) begin
                    we_d   = 1'b1;
                    hold_d = hold_q + HOLD_W'(1);
                end else if (hold_q == HOLD_W'(WE_HOLD - 1)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else if (word_idx_q == last_idx_q) begin
                    state_d = ST_CHK;
                end else begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    state_d    = ST_HI;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    halt_d = 1'b0;
                    if (byte_in == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CHK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = accepts_byte(state_d);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            halt_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            word_idx_q <= '0;
            last_idx_q <= '0;
            hold_q     <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            halt_q     <= halt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            word_idx_q <= word_idx_d;
            last_idx_q <= last_idx_d;
            hold_q     <= hold_d;
            csum_q     <= csum_d;
        end
    end

    assign byte_ready     = ready_q;
    assign we_insmem      = we_q;
    assign pc             = pc_q;
    assign instruction_in = instr_q;
    assign cpu_halt       = halt_q;
    assign load_done      = done_q;
    assign load_err       = err_q;

endmodule
